illm_d1_row_serializer: RTL and testbench



---
 rtl/illm_d1_row_serializer.sv | 144 ++++++++++++++
 tb/tb_illm_d1_row_serializer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/illm_d1_row_serializer.sv
// Double-banked row serializer: collects one 8-lane row of tokens and emits it
// as a single token stream in lane order, filling one bank while the other drains.
module illm_d1_row_serializer #(
  parameter int WIDTH = 9,
  parameter int LANES = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] b0_d,
  input  logic             b0_e,
  input  logic             b0_v,
  output logic             b0_b,
  input  logic [WIDTH-1:0] b1_d,
  input  logic             b1_e,
  input  logic             b1_v,
  output logic             b1_b,
  input  logic [WIDTH-1:0] b2_d,
  input  logic             b2_e,
  input  logic             b2_v,
  output logic             b2_b,
  input  logic [WIDTH-1:0] b3_d,
  input  logic             b3_e,
  input  logic             b3_v,
  output logic             b3_b,
  input  logic [WIDTH-1:0] b4_d,
  input  logic             b4_e,
  input  logic             b4_v,
  output logic             b4_b,
  input  logic [WIDTH-1:0] b5_d,
  input  logic             b5_e,
  input  logic             b5_v,
  output logic             b5_b,
  input  logic [WIDTH-1:0] b6_d,
  input  logic             b6_e,
  input  logic             b6_v,
  output logic             b6_b,
  input  logic [WIDTH-1:0] b7_d,
  input  logic             b7_e,
  input  logic             b7_v,
  output logic             b7_b,
  output logic [WIDTH-1:0] out_d,
  output logic             out_e,
  output logic             out_v,
  input  logic             out_b,
  output logic             err
);

  logic [WIDTH-1:0] in_d [LANES];
  logic [LANES-1:0] in_e;
  logic [LANES-1:0] in_v;
  logic [LANES-1:0] lane_b;

  // Each entry stores {e, d}; a bank is READY when ready_q is set, otherwise
  // the bank at fill_sel_q is FILLING and the other one is FREE.
  logic [WIDTH:0]   mem_q  [2][LANES];
  logic [LANES-1:0] flag_q [2];
  logic [1:0]       ready_q, ready_d;
  logic             fill_sel_q, fill_sel_d;
  logic             drain_sel_q, drain_sel_d;
  logic [2:0]       idx_q, idx_d;
  logic             err_q, err_d;

  logic             filling;
  logic [LANES-1:0] accept;
  logic [LANES-1:0] flags_all;
  logic [LANES-1:0] row_e;
  logic             fill_done;
  logic             mismatch;
  logic             drain_fire;
  logic             drain_done;

  assign in_d[0] = b0_d;
  assign in_d[1] = b1_d;
  assign in_d[2] = b2_d;
  assign in_d[3] = b3_d;
  assign in_d[4] = b4_d;
  assign in_d[5] = b5_d;
  assign in_d[6] = b6_d;
  assign in_d[7] = b7_d;
  assign in_e = {b7_e, b6_e, b5_e, b4_e, b3_e, b2_e, b1_e, b0_e};
  assign in_v = {b7_v, b6_v, b5_v, b4_v, b3_v, b2_v, b1_v, b0_v};
  assign {b7_b, b6_b, b5_b, b4_b, b3_b, b2_b, b1_b, b0_b} = lane_b;

  always_comb begin
    filling   = ~ready_q[fill_sel_q];
    lane_b    = flag_q[fill_sel_q] | {LANES{~filling | reset}};
    accept    = in_v & ~lane_b;
    flags_all = flag_q[fill_sel_q] | accept;
    fill_done = filling & (&flags_all);

    // e bits of the completing row: fresh value for lanes landing now, stored otherwise
    row_e = '0;
    for (int i = 0; i < LANES; i++) begin
      row_e[i] = accept[i] ? in_e[i] : mem_q[fill_sel_q][i][WIDTH];
    end
    mismatch = fill_done & ~((&row_e) | ~(|row_e));

    out_v      = ready_q[drain_sel_q];
    out_d      = out_v ? mem_q[drain_sel_q][idx_q][WIDTH-1:0] : '0;
    out_e      = out_v ? mem_q[drain_sel_q][idx_q][WIDTH] : 1'b0;
    drain_fire = out_v & ~out_b;
    drain_done = drain_fire & (idx_q == 3'd7);

    ready_d = ready_q;
    if (drain_done) ready_d[drain_sel_q] = 1'b0;
    if (fill_done)  ready_d[fill_sel_q]  = 1'b1;

    // Move filling to the other bank as soon as it is (or just became) free.
    fill_sel_d = fill_sel_q;
    if (ready_d[fill_sel_q] && !ready_d[~fill_sel_q]) fill_sel_d = ~fill_sel_q;

    drain_sel_d = drain_sel_q ^ drain_done;
    idx_d       = drain_fire ? idx_q + 3'd1 : idx_q;
    err_d       = err_q | mismatch;
  end

  assign err = err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      ready_q     <= '0;
      flag_q[0]   <= '0;
      flag_q[1]   <= '0;
      fill_sel_q  <= 1'b0;
      drain_sel_q <= 1'b0;
      idx_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      ready_q     <= ready_d;
      fill_sel_q  <= fill_sel_d;
      drain_sel_q <= drain_sel_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      for (int i = 0; i < LANES; i++) begin
        if (accept[i]) begin
          mem_q[fill_sel_q][i]  <= {in_e[i], in_d[i]};
          flag_q[fill_sel_q][i] <= 1'b1;
        end
      end
      if (drain_done) flag_q[drain_sel_q] <= '0;
    end
  end

endmodule

// File: tb/tb_illm_d1_row_serializer.sv
// Directed self-checking bench for illm_d1_row_serializer; inputs change and
// outputs are sampled on the falling clock edge.
module tb_illm_d1_row_serializer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] d [8];
  logic       e [8];
  logic       v [8];
  logic [7:0] bb;
  logic [8:0] out_d;
  logic       out_e;
  logic       out_v;
  logic       out_b = 1'b0;
  logic       err;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  illm_d1_row_serializer #(.WIDTH(9), .LANES(8)) dut (
    .clock(clock), .reset(reset),
    .b0_d(d[0]), .b0_e(e[0]), .b0_v(v[0]), .b0_b(bb[0]),
    .b1_d(d[1]), .b1_e(e[1]), .b1_v(v[1]), .b1_b(bb[1]),
    .b2_d(d[2]), .b2_e(e[2]), .b2_v(v[2]), .b2_b(bb[2]),
    .b3_d(d[3]), .b3_e(e[3]), .b3_v(v[3]), .b3_b(bb[3]),
    .b4_d(d[4]), .b4_e(e[4]), .b4_v(v[4]), .b4_b(bb[4]),
    .b5_d(d[5]), .b5_e(e[5]), .b5_v(v[5]), .b5_b(bb[5]),
    .b6_d(d[6]), .b6_e(e[6]), .b6_v(v[6]), .b6_b(bb[6]),
    .b7_d(d[7]), .b7_e(e[7]), .b7_v(v[7]), .b7_b(bb[7]),
    .out_d(out_d), .out_e(out_e), .out_v(out_v), .out_b(out_b), .err(err)
  );

  task automatic idle_lanes();
    for (int i = 0; i < 8; i++) begin
      v[i] = 1'b0;
      e[i] = 1'b0;
      d[i] = '0;
    end
  endtask

  task automatic test_reset();
    idle_lanes();
    for (int i = 0; i < 8; i++) v[i] = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (bb !== 8'hFF) begin errors++; $display("[TB] FAIL reset_bb got=%h exp=ff", bb); end
    checks++;
    if ({out_v, out_e, out_d, err} !== 12'h000) begin
      errors++; $display("[TB] FAIL reset_out got v=%b e=%b d=%0d err=%b exp all 0", out_v, out_e, out_d, err);
    end
    idle_lanes();
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (bb !== 8'h00) begin errors++; $display("[TB] FAIL post_reset_bb got=%h exp=00", bb); end
    checks++;
    if (out_v !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_outv got=%b exp=0", out_v); end
  endtask

  task automatic test_single_row();
    for (int i = 0; i < 8; i++) begin
      v[i] = 1'b1;
      d[i] = 9'(10 + i);
      e[i] = 1'b0;
    end
    @(negedge clock);
    idle_lanes();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({out_v, out_e, out_d} !== {1'b1, 1'b0, 9'(10 + k)}) begin
        errors++; $display("[TB] FAIL single_tok%0d got v=%b e=%b d=%0d exp v=1 e=0 d=%0d", k, out_v, out_e, out_d, 10 + k);
      end
      @(negedge clock);
    end
    checks++;
    if ({out_v, err} !== 2'b00) begin errors++; $display("[TB] FAIL single_end got v=%b err=%b exp 0 0", out_v, err); end
  endtask

  task automatic test_back_to_back();
    int  cnt [8];
    bit  pend [8];
    int  got = 0;
    int  gaps = 0;
    bit  started = 0;
    bit  early_b = 0;
    for (int i = 0; i < 8; i++) begin cnt[i] = 0; pend[i] = 0; end
    for (int cyc = 0; cyc < 80 && got < 24; cyc++) begin
      if (out_v) begin
        checks++;
        if (out_d !== 9'(32 + got)) begin
          errors++; $display("[TB] FAIL b2b_tok%0d got=%0d exp=%0d", got, out_d, 32 + got);
        end
        got++;
        started = 1;
      end else if (started) gaps++;
      if (cyc < 2 && bb !== 8'h00) early_b = 1;
      for (int i = 0; i < 8; i++) begin
        if (pend[i]) cnt[i]++;
        v[i] = (cnt[i] < 3);
        d[i] = 9'(32 + cnt[i] * 8 + i);
        pend[i] = v[i] && !bb[i];
      end
      @(negedge clock);
    end
    idle_lanes();
    checks++;
    if (got != 24) begin errors++; $display("[TB] FAIL b2b_count got=%0d exp=24", got); end
    checks++;
    if (gaps != 0) begin errors++; $display("[TB] FAIL b2b_gaps got=%0d exp=0", gaps); end
    checks++;
    if (early_b) begin errors++; $display("[TB] FAIL b2b_first_rows_b got=1 exp=0"); end
  endtask

  task automatic test_staggered();
    for (int s = 0; s < 8; s++) begin
      int lane = 7 - s;
      idle_lanes();
      v[lane] = 1'b1;
      d[lane] = 9'(100 + lane);
      if (lane < 3) begin
        v[3] = 1'b1;
        d[3] = 9'd250;
        checks++;
        if (bb[3] !== 1'b1) begin errors++; $display("[TB] FAIL stag_b3 step%0d got=%b exp=1", s, bb[3]); end
      end
      checks++;
      if (out_v !== 1'b0) begin errors++; $display("[TB] FAIL stag_early_v step%0d got=%b exp=0", s, out_v); end
      @(negedge clock);
    end
    idle_lanes();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({out_v, out_d} !== {1'b1, 9'(100 + k)}) begin
        errors++; $display("[TB] FAIL stag_tok%0d got v=%b d=%0d exp v=1 d=%0d", k, out_v, out_d, 100 + k);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_backpressure();
    int cnt [8];
    bit pend [8];
    int got = 0;
    for (int i = 0; i < 8; i++) begin cnt[i] = 0; pend[i] = 0; end
    out_b = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      for (int i = 0; i < 8; i++) begin
        if (pend[i]) cnt[i]++;
        v[i] = (cnt[i] < 3);
        d[i] = 9'(300 + cnt[i] * 8 + i);
        pend[i] = v[i] && !bb[i];
      end
      @(negedge clock);
    end
    checks++;
    if (bb !== 8'hFF) begin errors++; $display("[TB] FAIL bp_all_b got=%h exp=ff", bb); end
    checks++;
    if ({out_v, out_d} !== {1'b1, 9'd300}) begin
      errors++; $display("[TB] FAIL bp_hold got v=%b d=%0d exp v=1 d=300", out_v, out_d);
    end
    checks++;
    if (cnt[0] + (pend[0] ? 1 : 0) != 2) begin
      errors++; $display("[TB] FAIL bp_rows_taken got=%0d exp=2", cnt[0] + (pend[0] ? 1 : 0));
    end
    out_b = 1'b0;
    for (int cyc = 0; cyc < 80 && got < 24; cyc++) begin
      if (out_v) begin
        checks++;
        if (out_d !== 9'(300 + got)) begin
          errors++; $display("[TB] FAIL bp_tok%0d got=%0d exp=%0d", got, out_d, 300 + got);
        end
        got++;
      end
      for (int i = 0; i < 8; i++) begin
        if (pend[i]) cnt[i]++;
        v[i] = (cnt[i] < 3);
        d[i] = 9'(300 + cnt[i] * 8 + i);
        pend[i] = v[i] && !bb[i];
      end
      @(negedge clock);
    end
    idle_lanes();
    checks++;
    if (got != 24) begin errors++; $display("[TB] FAIL bp_count got=%0d exp=24", got); end
  endtask

  task automatic test_eos_err();
    checks++;
    if (err !== 1'b0) begin errors++; $display("[TB] FAIL eos_pre_err got=%b exp=0", err); end
    for (int i = 0; i < 8; i++) begin
      v[i] = 1'b1;
      d[i] = 9'(60 + i);
      e[i] = (i < 7);
    end
    @(negedge clock);
    idle_lanes();
    checks++;
    if (err !== 1'b1) begin errors++; $display("[TB] FAIL eos_err_set got=%b exp=1", err); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({out_v, out_e, out_d} !== {1'b1, (k < 7) ? 1'b1 : 1'b0, 9'(60 + k)}) begin
        errors++; $display("[TB] FAIL eos_tok%0d got v=%b e=%b d=%0d exp d=%0d", k, out_v, out_e, out_d, 60 + k);
      end
      @(negedge clock);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (err !== 1'b1) begin errors++; $display("[TB] FAIL eos_err_sticky got=%b exp=1", err); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) begin
      v[i] = 1'b1;
      d[i] = 9'(400 + i);
    end
    @(negedge clock);
    idle_lanes();
    for (int i = 0; i < 4; i++) begin
      v[i] = 1'b1;
      d[i] = 9'(450 + i);
    end
    @(negedge clock);
    idle_lanes();
    repeat (3) @(negedge clock);
    checks++;
    if ({out_v, out_d} !== {1'b1, 9'd404}) begin
      errors++; $display("[TB] FAIL mid_idx4 got v=%b d=%0d exp v=1 d=404", out_v, out_d);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({out_v, err, bb} !== {1'b0, 1'b0, 8'hFF}) begin
      errors++; $display("[TB] FAIL mid_reset got v=%b err=%b b=%h exp 0 0 ff", out_v, err, bb);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({out_v, bb} !== {1'b0, 8'h00}) begin
      errors++; $display("[TB] FAIL mid_after got v=%b b=%h exp 0 00", out_v, bb);
    end
    for (int i = 0; i < 8; i++) begin
      v[i] = 1'b1;
      d[i] = 9'(480 + i);
    end
    @(negedge clock);
    idle_lanes();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({out_v, out_d} !== {1'b1, 9'(480 + k)}) begin
        errors++; $display("[TB] FAIL mid_tok%0d got v=%b d=%0d exp v=1 d=%0d", k, out_v, out_d, 480 + k);
      end
      @(negedge clock);
    end
    checks++;
    if (out_v !== 1'b0) begin errors++; $display("[TB] FAIL mid_end_v got=%b exp=0", out_v); end
  endtask

  initial begin
    idle_lanes();
    @(negedge clock);
    test_reset();
    test_single_row();
    test_back_to_back();
    test_staggered();
    test_backpressure();
    test_eos_err();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
